shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle shifter datapath (computes `base` shifted by `power`) among `NREQ` neuron-side requesters. Each requester presents operands and holds a request. The block grants one requester at a time, issues a start pulse to the shifter, and waits for its done pulse. It then returns the result to the granted requester with a one-cycle acknowledge. It sits between the neuron compute units and the single shared shifter instance.

---
 rtl/shift_arbiter_if.sv | 28 ++
 rtl/shift_arbiter.sv | 111 +++++++++++
 tb/tb_shift_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: requester-side and shifter-side signals of shift_arbiter.
interface shift_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_base;
   logic [NREQ*WIDTH-1:0] req_power;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      result;
   logic                  err;
   logic                  busy;
   logic [WIDTH-1:0]      sh_base;
   logic [WIDTH-1:0]      sh_power;
   logic                  sh_start;
   logic [WIDTH-1:0]      sh_result;
   logic                  sh_done;

   modport slave (
      input  req, req_base, req_power, sh_result, sh_done,
      output ack, result, err, busy, sh_base, sh_power, sh_start
   );

   modport master (
      output req, req_base, req_power, sh_result, sh_done,
      input  ack, result, err, busy, sh_base, sh_power, sh_start
   );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one multi-cycle shifter among NREQ requesters.
// Optional WAIT timeout abort is enabled by defining SHIFT_ARB_TIMEOUT_EN.
module shift_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input logic            clk,
   input logic            rst_n,
   shift_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("shift_arbiter: NREQ must be 2..16");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("shift_arbiter: TIMEOUT must be >= 1");
   end

   logic [1:0]       state;
   logic [IW-1:0]    ptr, idx, win;
   logic [WIDTH-1:0] base_q, power_q, res_q;
   logic [WIDTH-1:0] base_a  [NREQ];
   logic [WIDTH-1:0] power_a [NREQ];
   logic             expire;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign base_a[g]  = bus.req_base[g*WIDTH +: WIDTH];
      assign power_a[g] = bus.req_power[g*WIDTH +: WIDTH];
   end

   // Scan from ptr+NREQ-1 down to ptr so the last hit is the nearest one above ptr.
   always_comb begin
      int p;
      logic [IW-1:0] pi;
      p   = 0;
      pi  = '0;
      win = ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         p  = int'(ptr) + k;
         p  = (p >= NREQ) ? p - NREQ : p;
         pi = IW'(p);
         win = bus.req[pi] ? pi : win;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         idx     <= '0;
         base_q  <= '0;
         power_q <= '0;
         res_q   <= '0;
      end else begin
         case (state)
            IDLE: if (|bus.req) begin
               idx     <= win;
               base_q  <= base_a[win];
               power_q <= power_a[win];
               state   <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (bus.sh_done || expire) begin
               res_q <= bus.sh_done ? bus.sh_result : '0;
               state <= RESP;
            end
            default: begin
               ptr   <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SHIFT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic          err_q;

   // cnt holds the number of WAIT cycles already elapsed, so it expires on the TIMEOUT-th one.
   assign expire = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         cnt   <= (state == ISSUE) ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
         err_q <= (state == WAIT) ? !bus.sh_done && expire : err_q;
      end
   end

   assign bus.err = (state == RESP) && err_q;
`else
   assign expire  = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.busy     = (state != IDLE);
   assign bus.sh_start = (state == ISSUE);
   assign bus.sh_base  = base_q;
   assign bus.sh_power = power_q;
   assign bus.ack      = (state == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;
   assign bus.result   = (state == RESP) ? res_q : '0;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed stimulus with a scoreboard of expected acks checked by a monitor.
module tb_shift_arbiter;
   typedef struct {
      logic [3:0]  ack;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic        clk, rst_n;
   logic        m_done, stray, mute;
   logic [31:0] m_res, m_b, m_p;
   logic [3:0]  rearm;
   int          lat;
   int          n_cmp, n_bad;
   exp_t        sb[$];

   shift_arbiter_if #(.NREQ(4), .WIDTH(32)) bus ();

   shift_arbiter #(.NREQ(4), .WIDTH(32), .TIMEOUT(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   assign bus.sh_done   = m_done | stray;
   assign bus.sh_result = m_done ? m_res : 32'hDEAD_BEEF;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic expect_ack(input logic [3:0] a, input logic [31:0] r, input logic e);
      exp_t x;
      x.ack = a;
      x.res = r;
      x.err = e;
      sb.push_back(x);
   endtask

   // Shifter model: result = base << power, done pulse lat cycles after the start cycle.
   initial begin
      m_done = 1'b0;
      m_res  = '0;
      forever begin
         @(negedge clk);
         if (bus.sh_start && !mute) begin
            m_b = bus.sh_base;
            m_p = bus.sh_power;
            repeat (lat) @(posedge clk);
            #1 m_done = 1'b1;
            m_res = m_b << m_p;
            @(posedge clk);
            #1 m_done = 1'b0;
         end
      end
   end

   // Monitor: every ack pops one expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.ack != 0) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: got ack %b result %0h with nothing expected", bus.ack, bus.result);
            end else begin
               e = sb.pop_front();
               chk("ack_vector", 64'(bus.ack), 64'(e.ack));
               chk("ack_result", 64'(bus.result), 64'(e.res));
               chk("ack_err", 64'(bus.err), 64'(e.err));
            end
         end
      end
   end

   // Requesters drop req on the cycle they see ack unless re-armed for one more round.
   task automatic tick();
      @(negedge clk);
      if (bus.ack != 0) begin
         bus.req = (bus.req & ~bus.ack) | (bus.ack & rearm);
         rearm   = rearm & ~bus.ack;
      end
   endtask

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.busy || bus.req != 0) && n < budget) begin
         tick();
         n++;
      end
      chk(nm, 64'(n < budget), 64'd1);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      bus.req  = '0;
      rearm    = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      stray = 1'b0;
      mute  = 1'b0;
      lat   = 3;
      bus.req_base  = {32'd7, 32'd5, 32'd3, 32'd2};
      bus.req_power = {32'd0, 32'd3, 32'd1, 32'd2};
      rst_n   = 1'b0;
      bus.req = '0;
      rearm   = '0;
      #1;
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_ack", 64'(bus.ack), 0);
      chk("rst_start", 64'(bus.sh_start), 0);
      chk("rst_sh_base", 64'(bus.sh_base), 0);
      chk("rst_sh_power", 64'(bus.sh_power), 0);
      chk("rst_result", 64'(bus.result), 0);
      chk("rst_err", 64'(bus.err), 0);
      do_reset();

      // single request, base 2 power 2, done 3 cycles after start
      expect_ack(4'b0001, 32'd8, 1'b0);
      bus.req = 4'b0001;
      tick();
      chk("t1_start", 64'(bus.sh_start), 1);
      chk("t1_sh_base", 64'(bus.sh_base), 2);
      chk("t1_sh_power", 64'(bus.sh_power), 2);
      bus.req_base[31:0] = 32'hFFFF;
      tick();
      chk("t1_start_once", 64'(bus.sh_start), 0);
      tick();
      tick();
      chk("t1_no_early_ack", 64'(bus.ack), 0);
      chk("t1_busy", 64'(bus.busy), 1);
      tick();
      chk("t1_ack_T5", 64'(bus.ack), 1);
      tick();
      chk("t1_idle_T6", 64'(bus.busy), 0);
      chk("t1_result_idle", 64'(bus.result), 0);
      bus.req_base[31:0] = 32'd2;
      drain("t1_drain", 20);

      // all four held, minimum latency; order 0,1,2,3,0
      do_reset();
      lat   = 1;
      rearm = 4'b0001;
      expect_ack(4'b0001, 32'd8, 1'b0);
      expect_ack(4'b0010, 32'd6, 1'b0);
      expect_ack(4'b0100, 32'd40, 1'b0);
      expect_ack(4'b1000, 32'd7, 1'b0);
      expect_ack(4'b0001, 32'd8, 1'b0);
      bus.req = 4'b1111;
      tick();
      tick();
      tick();
      chk("t2_min_latency", 64'(bus.ack), 64'b0001);
      drain("t2_drain", 100);

      // requester 2 re-requests, requester 3 arrives meanwhile and wins next
      do_reset();
      lat   = 2;
      rearm = 4'b0100;
      expect_ack(4'b0100, 32'd40, 1'b0);
      expect_ack(4'b1000, 32'd7, 1'b0);
      expect_ack(4'b0100, 32'd40, 1'b0);
      bus.req = 4'b0100;
      tick();
      tick();
      bus.req[3] = 1'b1;
      drain("t3_drain", 100);

      // reset during WAIT; late sh_done must be ignored, ptr restarts at 0
      lat     = 10;
      bus.req = 4'b0001;
      tick();
      tick();
      tick();
      rst_n   = 1'b0;
      bus.req = '0;
      #1;
      chk("t4_rst_busy", 64'(bus.busy), 0);
      chk("t4_rst_sh_base", 64'(bus.sh_base), 0);
      chk("t4_rst_sh_power", 64'(bus.sh_power), 0);
      chk("t4_rst_ack", 64'(bus.ack), 0);
      tick();
      rst_n = 1'b1;
      repeat (12) tick();
      chk("t4_idle_after_stray", 64'(bus.busy), 0);
      lat = 2;
      expect_ack(4'b0001, 32'd8, 1'b0);
      expect_ack(4'b1000, 32'd7, 1'b0);
      bus.req = 4'b1001;
      drain("t4_drain", 100);

      // sh_done in IDLE and in ISSUE is ignored
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      chk("t5_idle_stray_busy", 64'(bus.busy), 0);
      lat = 4;
      expect_ack(4'b0010, 32'd6, 1'b0);
      bus.req = 4'b0010;
      tick();
      chk("t5_issue", 64'(bus.sh_start), 1);
      stray = 1'b1;
      tick();
      stray = 1'b0;
      chk("t5_no_ack_T2", 64'(bus.ack), 0);
      chk("t5_busy_T2", 64'(bus.busy), 1);
      tick();
      tick();
      tick();
      chk("t5_no_ack_T5", 64'(bus.ack), 0);
      tick();
      chk("t5_ack_T6", 64'(bus.ack), 64'b0010);
      drain("t5_drain", 20);

`ifdef SHIFT_ARB_TIMEOUT_EN
      // shifter silent: abort after 4 WAIT cycles
      mute = 1'b1;
      expect_ack(4'b0001, 32'd0, 1'b1);
      bus.req = 4'b0001;
      repeat (5) tick();
      chk("t6_no_ack_T5", 64'(bus.ack), 0);
      tick();
      chk("t6_timeout_ack", 64'(bus.ack), 1);
      chk("t6_timeout_err", 64'(bus.err), 1);
      drain("t6_drain", 20);
      mute = 1'b0;
      // done on the 4th WAIT cycle wins over expiry
      lat = 4;
      expect_ack(4'b0001, 32'd8, 1'b0);
      bus.req = 4'b0001;
      repeat (6) tick();
      chk("t6_late_done_ack", 64'(bus.ack), 1);
      drain("t6b_drain", 20);
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
